// File: rtl/dsp48_mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// dsp48_mac_sequencer_if
// Operand-pair stream between the filter/datapath front end and the MAC
// sequencer. One pair moves on every cycle where in_valid and in_ready are
// both high.
//   in_valid  front end -> sequencer  operand pair present
//   in_ready  sequencer -> front end  sequencer accepts a pair this cycle
//   in_a      front end -> sequencer  signed 18-bit operand A
//   in_b      front end -> sequencer  signed 18-bit operand B
// Modports: master = front end (producer), slave = sequencer (consumer).
// ---------------------------------------------------------------------------
interface dsp48_mac_sequencer_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] in_a;
  logic signed [17:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/dsp48_mac_sequencer.sv
// ---------------------------------------------------------------------------
// dsp48_mac_sequencer
// Runs multiply-accumulate jobs on one DSP48A1 slice built with A/B, M and P
// pipeline registers. A job of len operand pairs is streamed in, each accepted
// pair launches a token down a 3-deep valid shift that drives CEA/CEB, CEM
// and CEP in turn, so stall bubbles never re-add a stale M into P. When the
// pipe is empty the accumulated P is captured into result and done pulses.
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   abort           (only with DSP_SEQ_ABORT_EN) cancel the running job
//   start, len      job request and pair count, sampled in IDLE
//   in_if           operand stream (slave modport)
//   dsp_a, dsp_b    registered operands to slice A/B
//   dsp_ce_ab/m/p   slice clock enables for A/B, M and P registers
//   dsp_rst_p       slice RSTP, clears the accumulator
//   dsp_opmode      slice OPMODE (constant OPMODE_ACC: X=M, Z=P, add)
//   dsp_p           slice P output
//   busy, done      job active / one-cycle completion pulse
//   result          accumulated P, held until the next done
//
// Build option: define DSP_SEQ_ABORT_EN to add the abort input. Abort in
// CLEAR, FEED or DRAIN empties the token pipe, returns to IDLE, pulses
// dsp_rst_p once and leaves result untouched.
// ---------------------------------------------------------------------------
module dsp48_mac_sequencer #(
  parameter int         CNT_W      = 8,
  parameter logic [7:0] OPMODE_ACC = 8'h09
) (
  input  logic                 CLK,
  input  logic                 RST,
`ifdef DSP_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 start,
  input  logic [CNT_W-1:0]     len,
  dsp48_mac_sequencer_if.slave in_if,
  output logic [17:0]          dsp_a,
  output logic [17:0]          dsp_b,
  output logic                 dsp_ce_ab,
  output logic                 dsp_ce_m,
  output logic                 dsp_ce_p,
  output logic                 dsp_rst_p,
  output logic [7:0]           dsp_opmode,
  input  logic [47:0]          dsp_p,
  output logic                 busy,
  output logic                 done,
  output logic [47:0]          result
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       v_r;
  logic             hs_s;
  logic             abort_s;
  logic             abort_hit_s;
  logic             in_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             rst_p_r;
  logic [17:0]      dsp_a_r;
  logic [17:0]      dsp_b_r;
  logic [47:0]      result_r;

`ifdef DSP_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode, handshake qualification and abort detection.
  always_comb begin
    state_next_s = state_r;
    hs_s         = 1'b0;
    abort_hit_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (len != CNT_ZERO) begin
            state_next_s = ST_CLEAR;
          end else begin
            state_next_s = ST_DONE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (abort_s) begin
          abort_hit_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FEED;
        end
      end
      ST_FEED: begin
        if (abort_s) begin
          abort_hit_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          hs_s = in_if.in_valid && in_ready_r;
          // The handshake that consumes the last pair ends the feed phase.
          if (hs_s && (cnt_r == CNT_ONE)) begin
            state_next_s = ST_DRAIN;
          end else begin
            state_next_s = ST_FEED;
          end
        end
      end
      ST_DRAIN: begin
        if (abort_s) begin
          abort_hit_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else if (v_r == 3'b000) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, token pipe, operand registers, counter and result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rst_p_r    <= 1'b0;
      v_r        <= 3'b000;
      cnt_r      <= CNT_ZERO;
      dsp_a_r    <= 18'd0;
      dsp_b_r    <= 18'd0;
      result_r   <= 48'd0;
    end else begin
      // Outputs are decoded from the next state so they line up with it.
      in_ready_r <= (state_next_s == ST_FEED);
      busy_r     <= (state_next_s != ST_IDLE);
      done_r     <= (state_next_s == ST_DONE);
      rst_p_r    <= (state_next_s == ST_CLEAR) || abort_hit_s;

      // Each accepted pair launches a token; empty slots become bubbles.
      if (abort_hit_s) begin
        v_r <= 3'b000;
      end else begin
        v_r <= {v_r[1:0], hs_s};
      end

      if ((state_r == ST_IDLE) && start) begin
        cnt_r <= len;
      end else if (hs_s) begin
        cnt_r <= cnt_r - CNT_ONE;
      end

      if (hs_s) begin
        dsp_a_r <= in_if.in_a;
        dsp_b_r <= in_if.in_b;
      end

      if ((state_r == ST_IDLE) && start && (len == CNT_ZERO)) begin
        result_r <= 48'd0;
      end else if ((state_r == ST_DRAIN) && (state_next_s == ST_DONE)) begin
        result_r <= dsp_p;
      end
    end
  end

  assign in_if.in_ready = in_ready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign dsp_rst_p      = rst_p_r;
  assign dsp_ce_ab      = v_r[0];
  assign dsp_ce_m       = v_r[1];
  assign dsp_ce_p       = v_r[2];
  assign dsp_a          = dsp_a_r;
  assign dsp_b          = dsp_b_r;
  assign dsp_opmode     = OPMODE_ACC;
  assign result         = result_r;

endmodule

// File: doc/dsp48_mac_sequencer.md
# dsp48_mac_sequencer

Control FSM that runs multiply-accumulate jobs on one DSP48A1 slice configured with A/B, M and P pipeline registers. It accepts a job length, streams operand pairs in over a valid/ready handshake, and drives the slice's clock enables, P reset and OPMODE so that bubbles never double-accumulate. When the job finishes it returns the 48-bit accumulated P. It sits between the filter/datapath front end and the DSP48A1 wrapper.

## Interface
Parameters:
- CNT_W, 8, width of job length / operand counter
- OPMODE_ACC, 8'h09, OPMODE driven during a job (X=M, Z=P, add)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, asynchronous, active-high
- start  in  1  job request; sampled only in IDLE
- len  in  CNT_W  number of operand pairs, sampled with start
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts a pair this cycle
- in_a  in  18  signed operand A
- in_b  in  18  signed operand B
- dsp_a  out  18  registered operand to slice A
- dsp_b  out  18  registered operand to slice B
- dsp_ce_ab  out  1  CEA/CEB of slice
- dsp_ce_m  out  1  CEM of slice
- dsp_ce_p  out  1  CEP of slice
- dsp_rst_p  out  1  RSTP of slice (clears accumulator)
- dsp_opmode  out  8  OPMODE of slice
- dsp_p  in  48  slice P output
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- result  out  48  accumulated P, held until next done

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: in_ready=0, busy=0. start&&len!=0 -> CLEAR and load counter with len. start&&len==0 -> DONE with result <= 0. start while not IDLE is ignored.
- CLEAR: dsp_rst_p=1 for exactly this cycle -> FEED.
- FEED: in_ready=1. A handshake (in_valid&&in_ready) registers in_a/in_b into dsp_a/dsp_b, pushes a token into a 3-bit valid shift v[0..2] and decrements the counter. A handshake that makes the counter 0 -> DRAIN, with in_ready low from the next cycle.
- The enables are driven by the tokens: dsp_ce_ab=v[0], dsp_ce_m=v[1], dsp_ce_p=v[2]. Stalls (in_valid=0) produce bubbles with all enables low for that token slot, so P never re-adds a stale M.
- DRAIN: wait until v==0. In that cycle result <= dsp_p, then go to DONE.
- DONE: done=1 for one cycle -> IDLE.
- dsp_opmode = OPMODE_ACC at all times after reset.
- dsp_a/dsp_b hold their value when no handshake occurs.

## Timing
- Reset values: state IDLE, in_ready=0, busy=0, done=0, result=0, dsp_a=dsp_b=0, all dsp_ce_*=0, dsp_rst_p=0, dsp_opmode=OPMODE_ACC, v=0.
- Cycle budget (start sampled at cycle s):
  - s+1: CLEAR.
  - From s+2: FEED; the first pair can be accepted at s+2.
  - The last handshake at cycle h gives ce_ab at h+1, ce_m at h+2 and ce_p at h+3.
  - h+4: DRAIN captures dsp_p.
  - h+5: done.
- No stalls: done occurs at s+len+6.
- len==0: done at s+1, result=0, no dsp_* enable or RSTP activity.
- RST mid-job: immediate return to IDLE with all outputs at reset values. The slice accumulator is cleared by the next job's CLEAR.
- Counter wrap: impossible, since len is at most 2^CNT_W-1 and the counter only decrements to 0.

## Configuration
- DSP_SEQ_ABORT_EN defined:
  - Adds input abort (1 bit).
  - abort=1 in CLEAR, FEED or DRAIN clears v and moves the FSM to IDLE next cycle.
  - dsp_rst_p pulses for one cycle in that transition; no done pulse; result unchanged.
  - abort in IDLE or DONE is ignored.
- Undefined: no abort port; a job can be stopped only by RST.

## Test plan
Bench uses a behavioural DSP48A1 model: A/B/M/P registers gated by the CEs, P=P+M, RSTP synchronous clear.
- len=3, pairs (2,3),(4,5),(-1,7), in_valid held high -> done at s+9, result=19, exactly three ce_p pulses.
- Same job with in_valid low for 2 cycles between pairs -> result=19, ce_p pulses separated by the bubbles, no extra accumulation.
- start with len=0 -> done at s+1, result=0, dsp_ce_ab/ce_m/ce_p/rst_p never asserted.
- Back-to-back jobs: len=1 (3,-4), then len=2 (100,100),(-5,2) -> results -12 and 9990; second job's CLEAR asserts dsp_rst_p.
- RST asserted mid-FEED after 1 of 4 pairs -> outputs at reset values immediately; a subsequent len=1 job (6,7) returns 42.
- With DSP_SEQ_ABORT_EN: abort in DRAIN -> IDLE next cycle, one dsp_rst_p pulse, no done, result retains previous value.
